// File: rtl/cp0_defs.sv
// ---------------------------------------------------------------------------
// cp0_defs
// Shared constants for the TLB exception responder slice:
//   - CP0 Cause.ExcCode values for the three TLB exceptions
//   - bit positions of those exceptions in the detector's exception vector
//   - handler vector offsets (refill vs. general)
//   - responder FSM state encoding
// ---------------------------------------------------------------------------
package cp0_defs;

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;

    localparam int EXC_BIT_MOD  = 1;
    localparam int EXC_BIT_TLBL = 2;
    localparam int EXC_BIT_TLBS = 3;

    localparam logic [31:0] VEC_OFF_REFILL  = 32'h0000_0000;
    localparam logic [31:0] VEC_OFF_GENERAL = 32'h0000_0180;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CAPTURE  = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

endpackage

// File: rtl/tlb_exc_vector_sel.sv
// ---------------------------------------------------------------------------
// tlb_exc_vector_sel
// Combinational decode of a captured TLB exception into its Cause.ExcCode
// and the exception handler PC.
// Ports:
//   exc_bits   in  3   exception vector bits [3:1] (TLBS, TLBL, Mod)
//   refill     in  1   cause was a TLB miss rather than an invalid entry
//   exl        in  1   Status.EXL at the time of the exception
//   bev        in  1   Status.BEV at the time of the exception
//   exccode    out 5   Cause.ExcCode (0 when no TLB bit is set)
//   handler_pc out 32  vector base + offset
// ---------------------------------------------------------------------------
module tlb_exc_vector_sel
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_BASE_BEV0 = 32'h8000_0000,
    parameter logic [31:0] EXC_BASE_BEV1 = 32'hBFC0_0200
) (
    input  logic [2:0]  exc_bits,
    input  logic        refill,
    input  logic        exl,
    input  logic        bev,
    output logic [4:0]  exccode,
    output logic [31:0] handler_pc
);

    logic [31:0] base;
    logic [31:0] offset;
    logic        is_tlb_ls;

    // TLBL wins over TLBS, which wins over Mod, when several bits are set.
    always_comb begin
        exccode = 5'd0;
        if (exc_bits[EXC_BIT_TLBL-1])
            exccode = EXC_TLBL;
        else if (exc_bits[EXC_BIT_TLBS-1])
            exccode = EXC_TLBS;
        else if (exc_bits[EXC_BIT_MOD-1])
            exccode = EXC_MOD;
    end

    // Only a first-level (EXL clear) load/store miss goes to the fast
    // refill vector; invalid entries, Mod and nested misses use the
    // general vector.
    always_comb begin
        is_tlb_ls  = (exccode == EXC_TLBL) || (exccode == EXC_TLBS);
        base       = bev ? EXC_BASE_BEV1 : EXC_BASE_BEV0;
        offset     = (refill && is_tlb_ls && !exl) ? VEC_OFF_REFILL : VEC_OFF_GENERAL;
        handler_pc = base + offset;
    end

endmodule

// File: rtl/tlb_exc_responder.sv
// ---------------------------------------------------------------------------
// tlb_exc_responder
// Accepts one TLB exception (Mod/TLBL/TLBS) from MEM, pulses the CP0
// context update, holds a pipeline flush until acknowledged and then hands
// the handler PC to fetch over a valid/ready handshake.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   exc_valid/exc_ready       request handshake (ready only when idle)
//   exc_type[31:0]            detector vector, bits 1/2/3 used
//   exc_refill, exc_badvaddr, exc_epc, exc_bd   exception context
//   status_exl, status_bev    current Status bits
//   cp0_*                     CP0 update strobe and values
//   flush_req/flush_ack       pipeline flush handshake
//   redir_valid/redir_pc/redir_ready  handler PC handshake to fetch
//   stat_mod/stat_tlbl/stat_tlbs      per-type counters
// Build option: define TLB_EXC_STATS_EN to build the counters; otherwise
// the counter ports are tied to 0.
// ---------------------------------------------------------------------------
module tlb_exc_responder
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_BASE_BEV0 = 32'h8000_0000,
    parameter logic [31:0] EXC_BASE_BEV1 = 32'hBFC0_0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    output logic        exc_ready,
    input  logic [31:0] exc_type,
    input  logic        exc_refill,
    input  logic [31:0] exc_badvaddr,
    input  logic [31:0] exc_epc,
    input  logic        exc_bd,
    input  logic        status_exl,
    input  logic        status_bev,
    output logic        cp0_we,
    output logic [31:0] cp0_badvaddr,
    output logic [18:0] cp0_vpn2,
    output logic        cp0_epc_we,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic [4:0]  cp0_exccode,
    output logic        cp0_set_exl,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic [31:0] stat_mod,
    output logic [31:0] stat_tlbl,
    output logic [31:0] stat_tlbs
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  type_q;
    logic        refill_q;
    logic [31:0] badvaddr_q;
    logic [31:0] epc_q;
    logic        bd_q;
    logic        exl_q;
    logic        bev_q;
    logic        accept;
    logic [4:0]  exccode;
    logic [31:0] handler_pc;
    logic        unused_type_bits;

    assign unused_type_bits = ^{exc_type[31:4], exc_type[0]};

    assign exc_ready = (state == ST_IDLE);
    assign accept    = exc_valid && exc_ready && (exc_type[3:1] != 3'b000);

    tlb_exc_vector_sel #(
        .EXC_BASE_BEV0 (EXC_BASE_BEV0),
        .EXC_BASE_BEV1 (EXC_BASE_BEV1)
    ) u_vector_sel (
        .exc_bits   (type_q),
        .refill     (refill_q),
        .exl        (exl_q),
        .bev        (bev_q),
        .exccode    (exccode),
        .handler_pc (handler_pc)
    );

    // Next-state logic: one CAPTURE cycle, an optional FLUSH wait, then
    // REDIRECT until fetch takes the handler PC.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept)      state_nxt = ST_CAPTURE;
            ST_CAPTURE:  state_nxt = flush_ack ? ST_REDIRECT : ST_FLUSH;
            ST_FLUSH:    if (flush_ack)   state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redir_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight exception.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Exception context is captured once on acceptance and held for the
    // whole sequence so redir_pc and the CP0 values stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q     <= 3'b000;
            refill_q   <= 1'b0;
            badvaddr_q <= 32'd0;
            epc_q      <= 32'd0;
            bd_q       <= 1'b0;
            exl_q      <= 1'b0;
            bev_q      <= 1'b0;
        end else if (accept) begin
            type_q     <= exc_type[3:1];
            refill_q   <= exc_refill;
            badvaddr_q <= exc_badvaddr;
            epc_q      <= exc_epc;
            bd_q       <= exc_bd;
            exl_q      <= status_exl;
            bev_q      <= status_bev;
        end
    end

    // EPC/BD are left alone on a nested exception so the outer return
    // address survives.
    assign cp0_we       = (state == ST_CAPTURE);
    assign cp0_set_exl  = cp0_we;
    assign cp0_epc_we   = cp0_we && !exl_q;
    assign cp0_badvaddr = badvaddr_q;
    assign cp0_vpn2     = badvaddr_q[31:13];
    assign cp0_epc      = epc_q;
    assign cp0_bd       = bd_q;
    assign cp0_exccode  = exccode;

    assign flush_req   = (state == ST_CAPTURE) || (state == ST_FLUSH);
    assign redir_valid = (state == ST_REDIRECT);
    assign redir_pc    = redir_valid ? handler_pc : 32'd0;

`ifdef TLB_EXC_STATS_EN
    // Per-type exception counters, bumped once per exception in CAPTURE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_mod  <= 32'd0;
            stat_tlbl <= 32'd0;
            stat_tlbs <= 32'd0;
        end else if (state == ST_CAPTURE) begin
            if (exccode == EXC_MOD)  stat_mod  <= stat_mod + 32'd1;
            if (exccode == EXC_TLBL) stat_tlbl <= stat_tlbl + 32'd1;
            if (exccode == EXC_TLBS) stat_tlbs <= stat_tlbs + 32'd1;
        end
    end
`else
    assign stat_mod  = 32'd0;
    assign stat_tlbl = 32'd0;
    assign stat_tlbs = 32'd0;
`endif

endmodule

// File: tb/tb_tlb_exc_responder.sv
// ---------------------------------------------------------------------------
// tb_tlb_exc_responder
// Directed and randomized transactions against a transaction-level model of
// the TLB exception responder. Inputs change on the falling edge, outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tlb_exc_responder;

    localparam logic [31:0] BASE0 = 32'h8000_0000;
    localparam logic [31:0] BASE1 = 32'hBFC0_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic        exc_ready;
    logic [31:0] exc_type;
    logic        exc_refill;
    logic [31:0] exc_badvaddr;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        status_exl;
    logic        status_bev;
    logic        cp0_we;
    logic [31:0] cp0_badvaddr;
    logic [18:0] cp0_vpn2;
    logic        cp0_epc_we;
    logic [31:0] cp0_epc;
    logic        cp0_bd;
    logic [4:0]  cp0_exccode;
    logic        cp0_set_exl;
    logic        flush_req;
    logic        flush_ack;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic [31:0] stat_mod;
    logic [31:0] stat_tlbl;
    logic [31:0] stat_tlbs;

    int total = 0;
    int bad   = 0;
    int expMod  = 0;
    int expTlbl = 0;
    int expTlbs = 0;
    bit statsOn;

    tlb_exc_responder dut (
        .clk          (clk),
        .rst          (rst),
        .exc_valid    (exc_valid),
        .exc_ready    (exc_ready),
        .exc_type     (exc_type),
        .exc_refill   (exc_refill),
        .exc_badvaddr (exc_badvaddr),
        .exc_epc      (exc_epc),
        .exc_bd       (exc_bd),
        .status_exl   (status_exl),
        .status_bev   (status_bev),
        .cp0_we       (cp0_we),
        .cp0_badvaddr (cp0_badvaddr),
        .cp0_vpn2     (cp0_vpn2),
        .cp0_epc_we   (cp0_epc_we),
        .cp0_epc      (cp0_epc),
        .cp0_bd       (cp0_bd),
        .cp0_exccode  (cp0_exccode),
        .cp0_set_exl  (cp0_set_exl),
        .flush_req    (flush_req),
        .flush_ack    (flush_ack),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .redir_ready  (redir_ready),
        .stat_mod     (stat_mod),
        .stat_tlbl    (stat_tlbl),
        .stat_tlbs    (stat_tlbs)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] modelCode(input logic [31:0] typ);
        if (typ[2])      return 5'd2;
        else if (typ[3]) return 5'd3;
        else             return 5'd1;
    endfunction

    function automatic logic [31:0] modelPc(input logic [4:0] code, input logic refill,
                                            input logic exl, input logic bev);
        logic [31:0] base;
        base = bev ? BASE1 : BASE0;
        if (refill && code != 5'd1 && !exl) return base;
        return base + 32'h180;
    endfunction

    task automatic checkStats();
        checkOutput("stat_mod",  stat_mod,  statsOn ? 32'(expMod)  : 32'd0);
        checkOutput("stat_tlbl", stat_tlbl, statsOn ? 32'(expTlbl) : 32'd0);
        checkOutput("stat_tlbs", stat_tlbs, statsOn ? 32'(expTlbs) : 32'd0);
    endtask

    // One full exception: d = cycles after CAPTURE before flush_ack rises,
    // r = cycles redir_ready stays low, rogue = keep a valid request
    // pending while the block is busy. Called on a falling edge while idle.
    task automatic applyStimulus(input logic [31:0] typ, input logic refill, input logic bd,
                                 input logic exl, input logic bev, input logic [31:0] va,
                                 input logic [31:0] epc, input int d, input int r, input bit rogue);
        logic [4:0]  code;
        logic [31:0] pc;
        int k;
        int flushCnt;
        int weCnt;
        int validCnt;
        bit done;
        code = modelCode(typ);
        pc   = modelPc(code, refill, exl, bev);
        exc_valid = 1'b1; exc_type = typ; exc_refill = refill; exc_bd = bd;
        status_exl = exl; status_bev = bev; exc_badvaddr = va; exc_epc = epc;
        flush_ack = 1'b0; redir_ready = 1'b0;
        @(negedge clk);
        checkOutput("cp0_we",       32'(cp0_we), 1);
        checkOutput("cp0_set_exl",  32'(cp0_set_exl), 1);
        checkOutput("cp0_exccode",  32'(cp0_exccode), 32'(code));
        checkOutput("cp0_badvaddr", cp0_badvaddr, va);
        checkOutput("cp0_vpn2",     32'(cp0_vpn2), 32'(va >> 13));
        checkOutput("cp0_epc_we",   32'(cp0_epc_we), 32'(!exl));
        checkOutput("cp0_epc",      cp0_epc, epc);
        checkOutput("cp0_bd",       32'(cp0_bd), 32'(bd));
        checkOutput("flush_req_cap", 32'(flush_req), 1);
        checkOutput("exc_ready_cap", 32'(exc_ready), 0);
        checkOutput("redir_valid_cap", 32'(redir_valid), 0);
        if (code == 5'd1) expMod++;
        else if (code == 5'd2) expTlbl++;
        else expTlbs++;
        if (rogue) begin
            exc_type = 32'h0000_0004; exc_badvaddr = $urandom; status_exl = ~exl;
        end else begin
            exc_valid = 1'b0;
        end
        flush_ack = (d == 0);
        flushCnt = 1; weCnt = 1; k = 0; done = 1'b0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (redir_valid) done = 1'b1;
            else begin
                if (flush_req) flushCnt++;
                if (cp0_we) weCnt++;
                flush_ack = (k >= d);
            end
        end
        flush_ack = 1'b0;
        checkOutput("flush_timeout", 32'(done), 1);
        checkOutput("flush_len", flushCnt, d + 1);
        checkOutput("redir_latency", k, d + 1);
        checkOutput("flush_req_redir", 32'(flush_req), 0);
        checkOutput("cp0_we_once", weCnt, 1);
        validCnt = 0; k = 0;
        while (redir_valid && k < 200) begin
            validCnt++;
            checkOutput("redir_pc", redir_pc, pc);
            checkOutput("exc_ready_busy", 32'(exc_ready), 0);
            redir_ready = (k >= r);
            @(negedge clk);
            k++;
        end
        redir_ready = 1'b0;
        checkOutput("redir_len", validCnt, r + 1);
        checkOutput("ready_after", 32'(exc_ready), 1);
        checkOutput("no_busy_accept", 32'(cp0_we), 0);
        exc_valid = 1'b0;
    endtask

    initial begin
`ifdef TLB_EXC_STATS_EN
        statsOn = 1'b1;
`else
        statsOn = 1'b0;
`endif
        rst = 1'b1; exc_valid = 1'b0; exc_type = 32'd0; exc_refill = 1'b0;
        exc_badvaddr = 32'd0; exc_epc = 32'd0; exc_bd = 1'b0; status_exl = 1'b0;
        status_bev = 1'b0; flush_ack = 1'b0; redir_ready = 1'b0;
        #3;
        checkOutput("rst_exc_ready",   32'(exc_ready), 1);
        checkOutput("rst_cp0_we",      32'(cp0_we), 0);
        checkOutput("rst_flush_req",   32'(flush_req), 0);
        checkOutput("rst_redir_valid", 32'(redir_valid), 0);
        checkOutput("rst_redir_pc",    redir_pc, 0);
        checkOutput("rst_exccode",     32'(cp0_exccode), 0);
        checkStats();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Request with no TLB bit set must be ignored.
        exc_valid = 1'b1; exc_type = 32'hFFFF_FFF1;
        @(negedge clk);
        checkOutput("ignored_ready", 32'(exc_ready), 1);
        checkOutput("ignored_we",    32'(cp0_we), 0);
        exc_valid = 1'b0;
        @(negedge clk);

        applyStimulus(32'h4, 1, 0, 0, 1, 32'h0040_2ABC, 32'h0040_0100, 0, 0, 0);
        applyStimulus(32'h8, 0, 0, 0, 0, 32'h1234_5678, 32'h0040_0200, 1, 1, 0);
        applyStimulus(32'h2, 1, 1, 1, 0, 32'hDEAD_B000, 32'h0040_0300, 5, 0, 0);
        applyStimulus(32'hE, 1, 0, 0, 1, 32'h7FFF_E000, 32'h0040_0400, 0, 3, 1);
        checkStats();

        // Reset in the middle of a flush wait.
        exc_valid = 1'b1; exc_type = 32'h4; exc_refill = 1'b1;
        @(negedge clk);
        exc_valid = 1'b0; flush_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_flush", 32'(flush_req), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready",  32'(exc_ready), 1);
        checkOutput("mid_rst_flush",  32'(flush_req), 0);
        checkOutput("mid_rst_we",     32'(cp0_we), 0);
        checkOutput("mid_rst_redir",  32'(redir_valid), 0);
        checkOutput("mid_rst_pc",     redir_pc, 0);
        checkOutput("mid_rst_va",     cp0_badvaddr, 0);
        expMod = 0; expTlbl = 0; expTlbs = 0;
        checkStats();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(32'h4, 1, 0, 0, 0, 32'h0000_2000, 32'h0000_1000, 2, 1, 0);
        applyStimulus(32'h4, 0, 0, 0, 1, 32'h0000_4000, 32'h0000_1004, 0, 0, 0);
        applyStimulus(32'h2, 1, 0, 0, 0, 32'h0000_6000, 32'h0000_1008, 1, 0, 0);
        checkStats();

        for (int i = 0; i < 30; i++) begin
            logic [31:0] typ;
            do typ = $urandom; while (typ[3:1] == 3'b000);
            applyStimulus(typ, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                          1'($urandom));
        end
        checkStats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_exc_responder.md
Name: tlb_exc_responder

Overview:
- Consumer end of the MEM-stage TLB exception detector's 32-bit exception-type vector.
- Accepts one TLB exception per request (bit1 = Mod, bit2 = TLBL, bit3 = TLBS) and writes the CP0 exception context (BadVAddr, EntryHi.VPN2, Context.BadVPN2, EPC, Cause.ExcCode/BD, Status.EXL).
- Holds the pipeline flush request until the pipeline acknowledges it, then issues the handler PC to fetch with a valid/ready handshake.
- Sits between the MEM stage, CP0 and the PC-select logic.

Parameters:
- EXC_BASE_BEV0, 32'h8000_0000, vector base when Status.BEV = 0.
- EXC_BASE_BEV1, 32'hBFC0_0200, vector base when Status.BEV = 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- exc_valid  in  1  exception request from MEM
- exc_ready  out  1  high only in IDLE
- exc_type  in  32  detector vector; bits 1/2/3 used, all others ignored
- exc_refill  in  1  cause is a TLB miss (not an invalid entry)
- exc_badvaddr  in  32  faulting virtual address
- exc_epc  in  32  PC of the faulting instruction, or of the branch if in a delay slot
- exc_bd  in  1  faulting instruction is in a delay slot
- status_exl  in  1  current Status.EXL
- status_bev  in  1  current Status.BEV
- cp0_we  out  1  one-cycle CP0 update strobe
- cp0_badvaddr  out  32  value for BadVAddr
- cp0_vpn2  out  19  badvaddr[31:13], for EntryHi.VPN2 and Context.BadVPN2
- cp0_epc_we  out  1  EPC/BD write enable (qualified by cp0_we)
- cp0_epc  out  32  value for EPC
- cp0_bd  out  1  value for Cause.BD
- cp0_exccode  out  5  value for Cause.ExcCode
- cp0_set_exl  out  1  set Status.EXL (equals cp0_we)
- flush_req  out  1  pipeline flush request
- flush_ack  in  1  pipeline flush complete
- redir_valid  out  1  handler PC valid
- redir_pc  out  32  handler PC
- redir_ready  in  1  fetch has accepted redir_pc

Behaviour:
- Reset values: every output is 0 except exc_ready = 1; state = IDLE.
- Reset is asynchronous and may be asserted mid-operation; it returns the block to IDLE and discards the captured exception.
- States: IDLE, CAPTURE, FLUSH, REDIRECT.
- IDLE:
  - A request is accepted when exc_valid & exc_ready and exc_type[3:1] != 0.
  - On acceptance, latch all inputs and move to CAPTURE.
  - exc_valid with exc_type[3:1] = 0 is ignored; the block stays in IDLE.
- ExcCode priority: bit2 → 2 (TLBL), else bit3 → 3 (TLBS), else bit1 → 1 (Mod).
- Vector selection:
  - base = status_bev ? EXC_BASE_BEV1 : EXC_BASE_BEV0.
  - offset = 0x000 if the latched refill is set, the latched code is TLBL or TLBS, and latched status_exl = 0.
  - offset = 0x180 otherwise.
  - redir_pc = base + offset, computed in 32-bit arithmetic with no carry out.
- CAPTURE (exactly one cycle):
  - cp0_we = 1 and cp0_set_exl = 1.
  - cp0_epc_we = ~latched status_exl, so EPC and BD are preserved on a nested exception.
  - flush_req = 1.
  - Next state: REDIRECT if flush_ack is already high this cycle, else FLUSH.
- FLUSH:
  - flush_req held at 1 until flush_ack is seen, then move to REDIRECT.
  - No timeout.
- REDIRECT:
  - flush_req = 0; redir_valid = 1, with redir_pc stable while valid.
  - When redir_valid & redir_ready, move to IDLE.
- Latency: redir_valid asserts at the earliest 2 cycles after acceptance (CAPTURE, then REDIRECT).
- exc_ready is low in CAPTURE, FLUSH and REDIRECT; requests presented in those states are not accepted.
- A request presented in the same cycle that REDIRECT completes is not accepted until the following IDLE cycle.

Optional Feature:
- Macro: TLB_EXC_STATS_EN.
- When defined:
  - Three 32-bit wrapping counters, stat_mod, stat_tlbl and stat_tlbs (output ports, reset 0).
  - The counter matching the selected ExcCode increments in the CAPTURE cycle.
- When undefined: the counter ports exist and are tied to 0; no counter flops are built.

Decomposition:
- Shared package (cp0_defs):
  - ExcCode constants EXC_MOD = 5'd1, EXC_TLBL = 5'd2, EXC_TLBS = 5'd3.
  - Exception-type bit indices 1/2/3.
  - Vector offsets 0x000 and 0x180.
  - State encoding.
- One natural sub-module: tlb_exc_vector_sel, a combinational block computing ExcCode and handler PC from type/refill/exl/bev.

Test Plan:
- exc_type = 0x4, refill = 1, exl = 0, bev = 1, badvaddr = 0x0040_2ABC, flush_ack immediate → cp0_we for 1 cycle; exccode = 2; vpn2 = 0x00201; cp0_epc_we = 1; redir_pc = 0xBFC0_0200 two cycles after accept.
- exc_type = 0x8, refill = 0, bev = 0 → exccode = 3, redir_pc = 0x8000_0180.
- exc_type = 0x2, exl = 1, exc_bd = 1 → cp0_epc_we = 0, exccode = 1, redir_pc = base + 0x180; flush_ack delayed 5 cycles → flush_req held 5 cycles and redir_valid only afterwards.
- exc_type = 0xE → exccode = 2 (priority); redir_ready low for 3 cycles → redir_pc stable; a second exc_valid during this window is not accepted.
- rst asserted in FLUSH → all outputs 0 and exc_ready = 1 on the same edge; a next request is handled normally.
- With TLB_EXC_STATS_EN defined: inject 2 TLBL and 1 Mod → stat_tlbl = 2, stat_mod = 1, stat_tlbs = 0.
